avalon_pattern_dma: RTL and testbench
=====================================

// Module: avalon_pattern_dma
// PURPOSE
// CSR-programmed Avalon-MM pattern engine; successor to the single-word switch-driven master/slave.
// PCIe host programs base/length/seed over the slave port, then starts a fill (burst of writes)
// or a verify (pipelined reads with up to MAX_PENDING outstanding) against SDRAM.
// Reports busy/done/abort, error count and checksum; one CSR is mirrored to the display.
// PARAMETERS
// MASTER_ADDRESSWIDTH  26           master byte-address width
// SLAVE_ADDRESSWIDTH   3            CSR index width (log2 NUMREGS)
// DATAWIDTH            32           data width, both ports
// NUMREGS              8            CSR count
// LENWIDTH             16           transfer length counter width (words)
// MAX_PENDING          4            max outstanding reads (>=1)
// ADDR_STEP            4            byte increment per word
// ADDR_LIMIT           26'h212C000  last legal word address; next address wraps to BASE
// PORTS
// clk           in   1                    clock
// reset_n       in   1                    async active-low reset
// display_sel   in   SLAVE_ADDRESSWIDTH   CSR index mirrored to display_data
// display_data  out  DATAWIDTH            CSR[display_sel], combinational
// slave_address/writedata/write/read/chipselect  in   Avalon-MM slave, CSR access
// slave_readdata                                 out  DATAWIDTH, 1-cycle read latency
// master_address  out  MASTER_ADDRESSWIDTH   registered
// master_writedata out DATAWIDTH             registered
// master_write/master_read  out  1           registered
// master_readdata in DATAWIDTH; master_readdatavalid in 1; master_waitrequest in 1
// BEHAVIOUR
// CSRs: 0 CTRL (b0 START self-clearing, b1 MODE 0=fill 1=verify, b2 ABORT self-clearing);
//   1 BASE; 2 LEN (words, 0 = no-op, done set immediately); 3 SEED; 4 STATUS RO
//   (b0 busy, b1 done, b2 aborted); 5 ERRCNT RO; 6 CHECKSUM RO; 7 WORDS_DONE RO.
// Host writes to RO regs ignored; writes to BASE/LEN/SEED/MODE while busy ignored.
// Reset (async): all CSRs 0, slave_readdata 0, master_read/write 0, address 0, writedata 0,
//   pending 0, state IDLE. Reset mid-transfer abandons outstanding reads silently.
// Pattern word i = SEED + i (mod 2^DATAWIDTH). Address: BASE, then +ADDR_STEP, wrap to BASE
//   when current == ADDR_LIMIT.
// States IDLE -> FILL | VERIFY -> DRAIN -> IDLE.
//   IDLE: START sampled -> clear done/aborted/ERRCNT/CHECKSUM/WORDS_DONE, set busy, enter
//     FILL/VERIFY; first request asserted the next cycle.
//   FILL: master_write held with stable addr/data while waitrequest=1; on accept
//     (write & !waitrequest) issue next word back-to-back; after LEN accepts -> DRAIN.
//   VERIFY: assert master_read when issued<LEN and pending<MAX_PENDING; held stable until
//     accepted; pending +1 on accept, -1 on readdatavalid, unchanged if both same cycle.
//     Each returned word: CHECKSUM += data, ERRCNT += (data != expected), WORDS_DONE += 1.
//     Expected words consumed in order. All issued -> DRAIN.
//   DRAIN: no new requests; pending==0 -> IDLE, busy=0, done=1.
//   ABORT while FILL/VERIFY: request in flight held until accepted, then no more issued;
//     go DRAIN, aborted=1 on exit. ABORT in IDLE ignored. START while busy ignored.
//   START and ABORT written same cycle: ABORT wins in busy, START wins in IDLE.
// Slave: write and read same cycle -> write wins, readdata unchanged. Out-of-range index ignored.
// ERRCNT/WORDS_DONE saturate at all-ones.
// STRUCTURE
// Package avalon_pattern_dma_pkg: state_t enum, CSR index localparams, CTRL/STATUS bit positions.
// Sub-module avalon_read_tracker: pending counter, expected-word index, full flag (pending==MAX_PENDING).
// TESTING
// Fill BASE=0x08000000 LEN=4 SEED=0x10, no wait -> writes 0x10..0x13 at +0,+4,+8,+C; done=1.
// Fill with waitrequest high 3 cycles on word 1 -> addr/data/write stable throughout; no dup words.
// Verify LEN=8, memory model latency 5, MAX_PENDING=4 -> never >4 pending; ERRCNT=0;
//   CHECKSUM = 8*SEED+28.
// Verify with word 3 corrupted -> ERRCNT=1, WORDS_DONE=8, done=1.
// BASE=ADDR_LIMIT-4, LEN=3 -> addresses ADDR_LIMIT-4, ADDR_LIMIT, BASE.
// ABORT after 2 of 16 reads accepted -> remaining 2 returns absorbed; aborted=1, busy=0;
//   reset_n low mid-verify -> all outputs at reset values immediately.

Source files
------------

// File: rtl/avalon_pattern_dma_pkg.sv
// Shared types and CSR map for the Avalon-MM pattern engine.
package avalon_pattern_dma_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StVerify, StDrain} state_t;

  localparam int unsigned CsrCtrl      = 0;
  localparam int unsigned CsrBase      = 1;
  localparam int unsigned CsrLen       = 2;
  localparam int unsigned CsrSeed      = 3;
  localparam int unsigned CsrStatus    = 4;
  localparam int unsigned CsrErrcnt    = 5;
  localparam int unsigned CsrChecksum  = 6;
  localparam int unsigned CsrWordsDone = 7;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlMode  = 1;
  localparam int unsigned CtrlAbort = 2;

  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatAborted = 2;

endpackage

// File: rtl/avalon_read_tracker.sv
// Outstanding-read bookkeeping for verify mode: pending count and index of the next
// expected return word.
module avalon_read_tracker #(
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned LENWIDTH    = 16,
  parameter int unsigned PENDWIDTH   = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 issue,
  input  logic                 readdatavalid,
  output logic                 retire,
  output logic [PENDWIDTH-1:0] pending,
  output logic                 full,
  output logic [LENWIDTH-1:0]  exp_idx
);

  logic [PENDWIDTH-1:0] pending_q, pending_d;
  logic [LENWIDTH-1:0]  idx_q, idx_d;

  // Returns with nothing outstanding (e.g. stale data after reset) are dropped.
  assign retire = readdatavalid && (pending_q != '0);

  always_comb begin
    pending_d = pending_q;
    if (issue && !retire) begin
      pending_d = pending_q + PENDWIDTH'(1);
    end else if (!issue && retire) begin
      pending_d = pending_q - PENDWIDTH'(1);
    end
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (retire) begin
      idx_d = idx_q + LENWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      idx_q     <= '0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
    end
  end

  assign pending = pending_q;
  // Looks at the post-update count so a request can be raised back-to-back safely.
  assign full    = (pending_d == PENDWIDTH'(MAX_PENDING));
  assign exp_idx = idx_q;

endmodule

// File: rtl/avalon_pattern_dma.sv
// CSR-programmed Avalon-MM pattern engine: fills SDRAM with SEED+i or verifies it with
// pipelined reads, reporting error count, checksum and words checked.
module avalon_pattern_dma
  import avalon_pattern_dma_pkg::*;
#(
  parameter int unsigned MASTER_ADDRESSWIDTH = 26,
  parameter int unsigned SLAVE_ADDRESSWIDTH  = 3,
  parameter int unsigned DATAWIDTH           = 32,
  parameter int unsigned NUMREGS             = 8,
  parameter int unsigned LENWIDTH            = 16,
  parameter int unsigned MAX_PENDING         = 4,
  parameter int unsigned ADDR_STEP           = 4,
  parameter logic [MASTER_ADDRESSWIDTH-1:0] ADDR_LIMIT = 26'h212C000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  display_sel,
  output logic [DATAWIDTH-1:0]           display_data,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  input  logic                           slave_write,
  input  logic                           slave_read,
  input  logic                           slave_chipselect,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  output logic                           master_read,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest
);

  localparam int unsigned PendWidth = $clog2(MAX_PENDING + 1);
  localparam int unsigned MAW = MASTER_ADDRESSWIDTH;
  localparam int unsigned DW  = DATAWIDTH;

  state_t               state_q, state_d;
  logic [LENWIDTH-1:0]  issued_q, issued_d, len_q, len_d;
  logic                 abort_q, abort_d, mode_q, mode_d;
  logic                 mwrite_q, mwrite_d, mread_q, mread_d;
  logic [MAW-1:0]       maddr_q, maddr_d;
  logic [DW-1:0]        mdata_q, mdata_d, base_q, base_d, seed_q, seed_d, rdata_q, rdata_d;
  logic                 busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic [DW-1:0]        errcnt_q, errcnt_d, checksum_q, checksum_d, words_q, words_d;

  logic                 trk_clear, trk_retire, trk_full;
  logic [PendWidth-1:0] trk_pending;
  logic [LENWIDTH-1:0]  trk_idx;
  logic [DW-1:0]        csr_view [NUMREGS];

  logic csr_wr, csr_rd, in_range, wr_ctrl, start_wr, abort_wr, abort_eff, accept_w, accept_r;
  logic [MAW-1:0] next_addr;

  assign csr_wr    = slave_chipselect && slave_write;
  assign csr_rd    = slave_chipselect && slave_read && !slave_write;
  assign in_range  = 32'(slave_address) < NUMREGS;
  assign wr_ctrl   = csr_wr && in_range && (32'(slave_address) == CsrCtrl);
  assign start_wr  = wr_ctrl && slave_writedata[CtrlStart];
  assign abort_wr  = wr_ctrl && slave_writedata[CtrlAbort];
  assign abort_eff = abort_q || abort_wr;
  assign accept_w  = mwrite_q && !master_waitrequest;
  assign accept_r  = mread_q && !master_waitrequest;
  assign next_addr = (maddr_q == ADDR_LIMIT) ? base_q[MAW-1:0] : maddr_q + MAW'(ADDR_STEP);

  avalon_read_tracker #(
    .MAX_PENDING (MAX_PENDING),
    .LENWIDTH    (LENWIDTH),
    .PENDWIDTH   (PendWidth)
  ) u_tracker (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (trk_clear),
    .issue         (accept_r),
    .readdatavalid (master_readdatavalid),
    .retire        (trk_retire),
    .pending       (trk_pending),
    .full          (trk_full),
    .exp_idx       (trk_idx)
  );

  always_comb begin
    for (int i = 0; i < int'(NUMREGS); i++) csr_view[i] = '0;
    csr_view[CsrCtrl][CtrlMode]        = mode_q;
    csr_view[CsrBase]                  = base_q;
    csr_view[CsrLen]                   = DW'(len_q);
    csr_view[CsrSeed]                  = seed_q;
    csr_view[CsrStatus][StatBusy]      = busy_q;
    csr_view[CsrStatus][StatDone]      = done_q;
    csr_view[CsrStatus][StatAborted]   = aborted_q;
    csr_view[CsrErrcnt]                = errcnt_q;
    csr_view[CsrChecksum]              = checksum_q;
    csr_view[CsrWordsDone]             = words_q;
  end

  assign display_data = (32'(display_sel) < NUMREGS) ? csr_view[display_sel] : '0;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    abort_d    = abort_q;
    mode_d     = mode_q;
    len_d      = len_q;
    base_d     = base_q;
    seed_d     = seed_q;
    mwrite_d   = mwrite_q;
    mread_d    = mread_q;
    maddr_d    = maddr_q;
    mdata_d    = mdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    aborted_d  = aborted_q;
    errcnt_d   = errcnt_q;
    checksum_d = checksum_q;
    words_d    = words_q;
    rdata_d    = rdata_q;
    trk_clear  = 1'b0;

    if (csr_wr && in_range && !busy_q) begin
      case (32'(slave_address))
        CsrCtrl: mode_d = slave_writedata[CtrlMode];
        CsrBase: base_d = slave_writedata;
        CsrLen:  len_d  = slave_writedata[LENWIDTH-1:0];
        CsrSeed: seed_d = slave_writedata;
        default: ;
      endcase
    end
    if (csr_rd) begin
      rdata_d = in_range ? csr_view[slave_address] : '0;
    end

    if (trk_retire) begin
      checksum_d = checksum_q + master_readdata;
      if ((master_readdata != seed_q + DW'(trk_idx)) && (errcnt_q != '1)) begin
        errcnt_d = errcnt_q + DW'(1);
      end
      if (words_q != '1) words_d = words_q + DW'(1);
    end

    case (state_q)
      StIdle: begin
        if (start_wr) begin
          trk_clear  = 1'b1;
          done_d     = 1'b0;
          aborted_d  = 1'b0;
          errcnt_d   = '0;
          checksum_d = '0;
          words_d    = '0;
          abort_d    = 1'b0;
          issued_d   = '0;
          maddr_d    = base_q[MAW-1:0];
          mdata_d    = seed_q;
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            if (slave_writedata[CtrlMode]) begin
              state_d = StVerify;
              mread_d = 1'b1;
            end else begin
              state_d  = StFill;
              mwrite_d = 1'b1;
            end
          end
        end
      end
      StFill: begin
        if (abort_wr) abort_d = 1'b1;
        if (accept_w) begin
          issued_d = issued_q + LENWIDTH'(1);
          maddr_d  = next_addr;
          mdata_d  = mdata_q + DW'(1);
          if ((issued_d == len_q) || abort_eff) begin
            mwrite_d = 1'b0;
            state_d  = StDrain;
          end
        end
      end
      StVerify: begin
        if (abort_wr) abort_d = 1'b1;
        if (accept_r) begin
          issued_d = issued_q + LENWIDTH'(1);
          maddr_d  = next_addr;
        end
        // A request still waiting on waitrequest is held untouched.
        if (!mread_q || accept_r) begin
          if ((issued_d == len_q) || abort_eff) begin
            mread_d = 1'b0;
            state_d = StDrain;
          end else begin
            mread_d = !trk_full;
          end
        end
      end
      StDrain: begin
        if (trk_pending == '0) begin
          state_d   = StIdle;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = abort_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      issued_q   <= '0;
      abort_q    <= 1'b0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      base_q     <= '0;
      seed_q     <= '0;
      mwrite_q   <= 1'b0;
      mread_q    <= 1'b0;
      maddr_q    <= '0;
      mdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      errcnt_q   <= '0;
      checksum_q <= '0;
      words_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      abort_q    <= abort_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      base_q     <= base_d;
      seed_q     <= seed_d;
      mwrite_q   <= mwrite_d;
      mread_q    <= mread_d;
      maddr_q    <= maddr_d;
      mdata_q    <= mdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      errcnt_q   <= errcnt_d;
      checksum_q <= checksum_d;
      words_q    <= words_d;
      rdata_q    <= rdata_d;
    end
  end

  assign slave_readdata   = rdata_q;
  assign master_address   = maddr_q;
  assign master_writedata = mdata_q;
  assign master_write     = mwrite_q;
  assign master_read      = mread_q;

endmodule

// File: tb/tb_avalon_pattern_dma.sv
// Randomized scoreboard bench for avalon_pattern_dma with an SDRAM-like memory model.
module tb_avalon_pattern_dma;

  localparam int MAXP = 4;
  localparam int LAT  = 5;
  localparam logic [25:0] LIMIT = 26'h212C000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  display_sel = 3'd4;
  logic [31:0] display_data;
  logic [2:0]  slave_address = '0;
  logic [31:0] slave_writedata = '0;
  logic        slave_write = 1'b0, slave_read = 1'b0, slave_chipselect = 1'b0;
  logic [31:0] slave_readdata;
  logic [25:0] master_address;
  logic [31:0] master_writedata;
  logic        master_write, master_read;
  logic [31:0] master_readdata = '0;
  logic        master_readdatavalid = 1'b0;
  logic        master_waitrequest = 1'b0;

  avalon_pattern_dma #(
    .MASTER_ADDRESSWIDTH (26),
    .SLAVE_ADDRESSWIDTH  (3),
    .DATAWIDTH           (32),
    .NUMREGS             (8),
    .LENWIDTH            (16),
    .MAX_PENDING         (MAXP),
    .ADDR_STEP           (4),
    .ADDR_LIMIT          (LIMIT)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .display_sel          (display_sel),
    .display_data         (display_data),
    .slave_address        (slave_address),
    .slave_writedata      (slave_writedata),
    .slave_write          (slave_write),
    .slave_read           (slave_read),
    .slave_chipselect     (slave_chipselect),
    .slave_readdata       (slave_readdata),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_write         (master_write),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: word store, fixed read latency, programmable waitrequest.
  typedef struct {logic [31:0] data; int due;} ret_t;
  logic [31:0] mem [logic [25:0]];
  ret_t        rq [$];
  ret_t        r;
  int          cyc = 0;
  int          stall_mode = 0;
  logic [25:0] stall_addr = '0;
  int          stall_left = 0;

  always begin
    @(negedge clk);
    if (!reset_n) begin
      rq.delete();
    end else begin
      if (master_write && !master_waitrequest) mem[master_address] = master_writedata;
      if (master_read && !master_waitrequest) begin
        r.data = mem.exists(master_address) ? mem[master_address] : 32'h0;
        r.due  = cyc + LAT;
        rq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    master_readdatavalid = 1'b0;
    master_readdata      = $urandom;
    if (reset_n && rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      master_readdatavalid = 1'b1;
      master_readdata      = r.data;
    end
    case (stall_mode)
      1: master_waitrequest = ($urandom_range(0, 3) == 0);
      2: begin
        master_waitrequest = 1'b0;
        if (master_write && master_address == stall_addr && stall_left > 0) begin
          master_waitrequest = 1'b1;
          stall_left--;
        end
      end
      default: master_waitrequest = 1'b0;
    endcase
  end

  // Scoreboard monitor: expected transfers queued by the stimulus side.
  logic [25:0] exp_wa_q [$];
  logic [31:0] exp_wd_q [$];
  logic [25:0] exp_ra_q [$];
  int acc_rd = 0, ret_rd = 0, max_out = 0, stall_seen = 0, outs;
  logic held_w = 1'b0, held_r = 1'b0;
  logic [25:0] held_a;
  logic [31:0] held_d;

  always begin
    @(negedge clk);
    if (!reset_n) begin
      held_w = 1'b0;
      held_r = 1'b0;
    end else begin
      if (held_w) check("write held stable", {master_write, master_address, master_writedata},
                        {1'b1, held_a, held_d});
      if (held_r) check("read held stable", {master_read, master_address}, {1'b1, held_a});
      if (master_write && master_waitrequest) stall_seen++;
      if (master_readdatavalid) ret_rd++;
      if (master_write && !master_waitrequest) begin
        if (exp_wa_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none required",
                   master_address, master_writedata);
        end else begin
          check("write address", master_address, exp_wa_q.pop_front());
          check("write data", master_writedata, exp_wd_q.pop_front());
        end
      end
      if (master_read && !master_waitrequest) begin
        acc_rd++;
        if (exp_ra_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected read: addr 0x%0h, none required", master_address);
        end else begin
          check("read address", master_address, exp_ra_q.pop_front());
        end
        outs = acc_rd - ret_rd;
        if (outs > max_out) max_out = outs;
        check("reads outstanding within limit", outs <= MAXP, 1);
      end
      held_w = master_write && master_waitrequest;
      held_r = master_read && master_waitrequest;
      held_a = master_address;
      held_d = master_writedata;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_write(input int a, input logic [31:0] d);
    slave_address = 3'(a);
    slave_writedata = d;
    slave_write = 1'b1;
    slave_chipselect = 1'b1;
    tick();
    slave_write = 1'b0;
    slave_chipselect = 1'b0;
  endtask

  task automatic csr_check(input int a, input logic [31:0] exp, input string name);
    slave_address = 3'(a);
    slave_read = 1'b1;
    slave_chipselect = 1'b1;
    tick();
    slave_read = 1'b0;
    slave_chipselect = 1'b0;
    check(name, slave_readdata, exp);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    display_sel = 3'd4;
    while (display_data[0] && n < 2000) begin
      tick();
      n++;
    end
    check({tag, " completes"}, n < 2000, 1);
    tick(2);
  endtask

  task automatic preload(input logic [31:0] base, input int len, input logic [31:0] seed,
                         input int bad);
    logic [25:0] a = base[25:0];
    for (int i = 0; i < len; i++) begin
      mem[a] = (i == bad) ? ~(seed + 32'(i)) : seed + 32'(i);
      a = (a == LIMIT) ? base[25:0] : a + 26'd4;
    end
  endtask

  // Reference: expected transfers and results straight from the pattern/address rules.
  task automatic run_job(input bit mode, input logic [31:0] base, input int len,
                         input logic [31:0] seed, input logic [31:0] extra, input string tag);
    logic [25:0] a;
    logic [31:0] d, exp_sum;
    int exp_err;
    csr_write(1, base);
    csr_write(2, 32'(len));
    csr_write(3, seed);
    a = base[25:0];
    exp_err = 0;
    exp_sum = 0;
    for (int i = 0; i < len; i++) begin
      if (!mode) begin
        exp_wa_q.push_back(a);
        exp_wd_q.push_back(seed + 32'(i));
      end else begin
        exp_ra_q.push_back(a);
        d = mem.exists(a) ? mem[a] : 32'h0;
        exp_sum += d;
        if (d != seed + 32'(i)) exp_err++;
      end
      a = (a == LIMIT) ? base[25:0] : a + 26'd4;
    end
    csr_write(0, {29'b0, 1'b0, mode, 1'b1} | extra);
    if (len > 0) check({tag, " first request next cycle"}, master_write | master_read, 1);
    wait_done(tag);
    csr_check(4, 32'h2, {tag, " status"});
    csr_check(5, 32'(exp_err), {tag, " errcnt"});
    csr_check(6, mode ? exp_sum : 32'h0, {tag, " checksum"});
    csr_check(7, mode ? 32'(len) : 32'h0, {tag, " words_done"});
    check({tag, " all writes seen"}, exp_wa_q.size(), 0);
    check({tag, " all reads seen"}, exp_ra_q.size(), 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] seed, base;
    int acc0, n, len, bad;
    bit mode;
    #1;
    reset_n = 1'b0;
    #1;
    check("reset master outputs", {master_write, master_read, master_address, master_writedata},
          '0);
    tick(3);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) csr_check(i, 32'h0, $sformatf("reset csr %0d", i));
    csr_write(5, 32'h55);
    csr_check(5, 32'h0, "errcnt read-only");
    csr_write(4, 32'h7);
    csr_check(4, 32'h0, "status read-only");

    run_job(0, 32'h0800_0000, 4, 32'h10, 0, "fill basic");

    seed = $urandom;
    base = 32'h0000_1000;
    stall_mode = 2;
    stall_addr = 26'h1004;
    stall_left = 3;
    stall_seen = 0;
    run_job(0, base, 6, seed, 0, "fill stall");
    check("fill stall cycles observed", stall_seen, 3);
    stall_mode = 0;

    seed = $urandom;
    base = 32'($urandom_range(0, 32'h84B000)) << 2;
    preload(base, 8, seed, -1);
    max_out = 0;
    run_job(1, base, 8, seed, 0, "verify8");
    csr_check(6, seed * 8 + 32'd28, "verify8 checksum formula");
    check("verify8 pipeline reaches limit", max_out, MAXP);

    seed = $urandom;
    preload(32'h200, 8, seed, 3);
    run_job(1, 32'h200, 8, seed, 0, "verify corrupt");
    csr_check(5, 32'h1, "verify corrupt errcnt is one");

    run_job(0, 32'(LIMIT) - 32'd4, 3, $urandom, 0, "wrap");
    run_job(0, 32'h40, 0, 32'h99, 0, "len zero");

    for (int k = 0; k < 4; k++) begin
      stall_mode = 1;
      mode = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      seed = $urandom;
      base = 32'($urandom_range(0, 32'h84B000)) << 2;
      bad = $urandom_range(0, len);
      if (mode) preload(base, len, seed, bad);
      // First job also carries ABORT with START from idle; START must win.
      run_job(mode, base, len, seed, (k == 0) ? 32'h4 : 32'h0, $sformatf("random %0d", k));
    end
    stall_mode = 0;

    seed = $urandom;
    preload(32'h100, 16, seed, -1);
    csr_write(1, 32'h100);
    csr_write(2, 32'd16);
    csr_write(3, seed);
    for (int i = 0; i < 16; i++) exp_ra_q.push_back(26'h100 + 26'(4 * i));
    acc0 = acc_rd;
    csr_write(0, 32'h3);
    csr_write(1, 32'h4444);
    n = 0;
    while (acc_rd - acc0 < 2 && n < 100) begin
      tick();
      n++;
    end
    check("abort wait for two reads", n < 100, 1);
    csr_write(0, 32'h5);
    wait_done("abort");
    csr_check(4, 32'h6, "abort status");
    csr_check(7, 32'(acc_rd - acc0), "abort words equal accepted reads");
    check("abort stopped early", (acc_rd - acc0) < 16, 1);
    check("abort returns absorbed", ret_rd, acc_rd);
    csr_check(5, 32'h0, "abort errcnt");
    csr_check(1, 32'h100, "base write while busy ignored");
    exp_ra_q.delete();

    seed = $urandom | 32'h1;
    preload(32'h300, 16, seed, -1);
    csr_write(1, 32'h300);
    csr_write(2, 32'd16);
    csr_write(3, seed);
    for (int i = 0; i < 16; i++) exp_ra_q.push_back(26'h300 + 26'(4 * i));
    csr_write(0, 32'h3);
    csr_check(3, seed, "seed readable while busy");
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid-verify reset master outputs",
          {master_write, master_read, master_address, master_writedata}, '0);
    check("mid-verify reset readdata", slave_readdata, 0);
    check("mid-verify reset status", display_data, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(2);
    exp_ra_q.delete();
    csr_check(4, 32'h0, "status after reset");
    csr_check(3, 32'h0, "seed after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
